// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer and its target calculator.
package pc_seq_pkg;

   localparam int              PC_W        = 64;
   localparam logic [PC_W-1:0] PC_INCR_DEF = 64'd4;

   typedef enum logic [2:0] {
      BOOT,
      FETCH,
      WAIT,
      HOLD,
      REDIRECT,
      TRAP
   } seq_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Branch taken decode and target address (BrPC + imm*4, wrapping modulo 2^64).
// PC_SEQ_ALIGN_TRAP_EN: keep raw target and report misalignment instead of clearing bits[1:0].
module pc_target_calc
   import pc_seq_pkg::*;
(
   input  logic                   br_valid,
   input  logic                   branch,
   input  logic                   alu_zero,
   input  logic                   uncond,
   input  logic [PC_W-1:0]        br_pc,
   input  logic signed [PC_W-1:0] br_imm,
   output logic                   taken,
   output logic [PC_W-1:0]        target
`ifdef PC_SEQ_ALIGN_TRAP_EN
   ,
   output logic                   misalign
`endif
);

   logic [PC_W-1:0] offset;
   logic [PC_W-1:0] sum;

   assign taken  = br_valid && ((alu_zero && branch) || uncond);
   assign offset = br_imm <<< 2;
   assign sum    = br_pc + offset;

`ifdef PC_SEQ_ALIGN_TRAP_EN
   assign target   = sum;
   assign misalign = |sum[1:0];
`else
   assign target   = sum & {{(PC_W-2){1'b1}}, 2'b00};
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: issues fetches, steps the PC, redirects on taken branches.
// PC_SEQ_ALIGN_TRAP_EN: misaligned branch targets park the sequencer in TRAP until reset.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 64'h0,
   parameter logic [PC_W-1:0] PC_INCR  = PC_INCR_DEF
) (
   input  logic                   CLK,
   input  logic                   Reset,
   output logic                   FetchValid,
   input  logic                   FetchReady,
   output logic [PC_W-1:0]        FetchPC,
   input  logic                   InstrValid,
   input  logic                   Stall,
   input  logic                   BrValid,
   input  logic [PC_W-1:0]        BrPC,
   input  logic signed [PC_W-1:0] BrImm,
   input  logic                   Branch,
   input  logic                   ALUZero,
   input  logic                   Uncondbranch,
   output logic                   Flush,
   output logic [PC_W-1:0]        CurrentPC,
   output logic                   Trap
);

   seq_state_t      state, state_nx;
   logic [PC_W-1:0] pc_q, pc_nx;
   logic            outst_q, outst_nx;
   logic            fv_q, flush_q, flush_nx;
   logic            taken, br_ok;
   logic [PC_W-1:0] target;
`ifdef PC_SEQ_ALIGN_TRAP_EN
   logic            misalign;
   logic            trap_q;
`endif

   pc_target_calc u_tgt (
      .br_valid (BrValid),
      .branch   (Branch),
      .alu_zero (ALUZero),
      .uncond   (Uncondbranch),
      .br_pc    (BrPC),
      .br_imm   (BrImm),
      .taken    (taken),
      .target   (target)
`ifdef PC_SEQ_ALIGN_TRAP_EN
      ,
      .misalign (misalign)
`endif
   );

   // Branches only count while a fetch stream is live.
   assign br_ok = taken && (state == FETCH || state == WAIT || state == HOLD);

   always_comb begin
      state_nx = state;
      pc_nx    = pc_q;
      outst_nx = outst_q;
      flush_nx = 1'b0;

      if (fv_q && FetchReady)
         outst_nx = 1'b1;
      else if (InstrValid)
         outst_nx = 1'b0;

      if (br_ok) begin
         pc_nx    = target;
         flush_nx = 1'b1;
         state_nx = REDIRECT;
`ifdef PC_SEQ_ALIGN_TRAP_EN
         if (misalign)
            state_nx = TRAP;
`endif
      end else begin
         case (state)
            BOOT:     state_nx = FETCH;
            FETCH:    if (fv_q && FetchReady) state_nx = WAIT;
            WAIT: begin
               if (InstrValid) begin
                  if (Stall) begin
                     state_nx = HOLD;
                  end else begin
                     pc_nx    = pc_q + PC_INCR;
                     state_nx = FETCH;
                  end
               end
            end
            HOLD: begin
               if (!Stall) begin
                  pc_nx    = pc_q + PC_INCR;
                  state_nx = FETCH;
               end
            end
            // The killed fetch's response is swallowed here without touching the PC.
            REDIRECT: if (!outst_q || InstrValid) state_nx = FETCH;
            TRAP:     state_nx = TRAP;
            default:  state_nx = BOOT;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state   <= BOOT;
         pc_q    <= RESET_PC;
         outst_q <= 1'b0;
         fv_q    <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         state   <= state_nx;
         pc_q    <= pc_nx;
         outst_q <= outst_nx;
         fv_q    <= (state_nx == FETCH);
         flush_q <= flush_nx;
      end
   end

`ifdef PC_SEQ_ALIGN_TRAP_EN
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) trap_q <= 1'b0;
      else       trap_q <= (state_nx == TRAP);
   end
   assign Trap = trap_q;
`else
   assign Trap = 1'b0;
`endif

   assign FetchValid = fv_q;
   assign FetchPC    = pc_q;
   assign CurrentPC  = pc_q;
   assign Flush      = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, corner sequences, randomized model check.
module tb_pc_sequencer;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        FetchValid, FetchReady, InstrValid, Stall;
   logic        BrValid, Branch, ALUZero, Uncondbranch, Flush, Trap;
   logic [63:0] FetchPC, CurrentPC, BrPC, BrImm;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic        m_fv, m_fl, m_boot, m_drain, m_got;
   int          owed;
   logic [63:0] m_pc;

   typedef struct {
      logic [6:0]  in;   // {FetchReady, InstrValid, Stall, BrValid, Branch, ALUZero, Uncondbranch}
      logic [63:0] bpc;
      logic [63:0] bimm;
      logic        efv;
      logic [63:0] epc;
      logic        efl;
   } vec_t;

   vec_t tv[$];

   pc_sequencer #(.RESET_PC(64'h0), .PC_INCR(64'd4)) dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .FetchValid   (FetchValid),
      .FetchReady   (FetchReady),
      .FetchPC      (FetchPC),
      .InstrValid   (InstrValid),
      .Stall        (Stall),
      .BrValid      (BrValid),
      .BrPC         (BrPC),
      .BrImm        (BrImm),
      .Branch       (Branch),
      .ALUZero      (ALUZero),
      .Uncondbranch (Uncondbranch),
      .Flush        (Flush),
      .CurrentPC    (CurrentPC),
      .Trap         (Trap)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic expect_o(input string nm, input logic efv, input logic [63:0] epc,
                           input logic efl, input logic etr);
      chk({nm, ".FetchValid"}, 64'(FetchValid), 64'(efv));
      chk({nm, ".FetchPC"},    FetchPC,         epc);
      chk({nm, ".CurrentPC"},  CurrentPC,       epc);
      chk({nm, ".Flush"},      64'(Flush),      64'(efl));
      chk({nm, ".Trap"},       64'(Trap),       64'(etr));
   endtask

   task automatic drv(input logic [6:0] in, input logic [63:0] bpc, input logic [63:0] bimm);
      {FetchReady, InstrValid, Stall, BrValid, Branch, ALUZero, Uncondbranch} = in;
      BrPC  = bpc;
      BrImm = bimm;
   endtask

   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset;
      drv(7'b0, 64'h0, 64'h0);
      Reset = 1'b1;
      tick();
      expect_o("reset", 1'b0, 64'h0, 1'b0, 1'b0);
      Reset = 1'b0;
   endtask

   task automatic add(input logic [6:0] in, input logic [63:0] bpc, input logic [63:0] bimm,
                      input logic efv, input logic [63:0] epc, input logic efl);
      vec_t v;
      v.in = in; v.bpc = bpc; v.bimm = bimm; v.efv = efv; v.epc = epc; v.efl = efl;
      tv.push_back(v);
   endtask

   task automatic model_step;
      logic tk, acc, resp, nfl;
      tk   = BrValid && ((ALUZero && Branch) || Uncondbranch);
      acc  = m_fv && FetchReady;
      resp = InstrValid && (owed > 0);
      owed = owed - int'(resp) + int'(acc);
      nfl  = 1'b0;
      if (m_boot) begin
         m_boot = 1'b0; m_fv = 1'b1;
      end else if (m_drain) begin
         if (owed == 0) begin m_drain = 1'b0; m_fv = 1'b1; end
      end else if (tk) begin
         m_pc = (BrPC + BrImm * 64'd4) & ~64'h3;
         m_fv = 1'b0; m_got = 1'b0; m_drain = 1'b1; nfl = 1'b1;
      end else if (m_fv) begin
         if (acc) m_fv = 1'b0;
      end else if (resp) begin
         if (Stall) m_got = 1'b1;
         else begin m_pc = m_pc + 64'd4; m_fv = 1'b1; end
      end else if (m_got && !Stall) begin
         m_got = 1'b0; m_pc = m_pc + 64'd4; m_fv = 1'b1;
      end
      m_fl = nfl;
   endtask

   initial begin
      // in: {ready, ivalid, stall, brvalid, branch, aluzero, uncond}
      add(7'b1100000, 64'h0,   64'h0, 1'b0, 64'h0,  1'b0); // BOOT
      add(7'b1100000, 64'h0,   64'h0, 1'b1, 64'h0,  1'b0);
      add(7'b1100000, 64'h0,   64'h0, 1'b0, 64'h0,  1'b0);
      add(7'b1100000, 64'h0,   64'h0, 1'b1, 64'h4,  1'b0);
      add(7'b1100000, 64'h0,   64'h0, 1'b0, 64'h4,  1'b0);
      add(7'b1100000, 64'h0,   64'h0, 1'b1, 64'h8,  1'b0);
      add(7'b1100000, 64'h0,   64'h0, 1'b0, 64'h8,  1'b0);
      add(7'b1100000, 64'h0,   64'h0, 1'b1, 64'hC,  1'b0);
      add(7'b1100000, 64'h0,   64'h0, 1'b0, 64'hC,  1'b0);
      add(7'b0000000, 64'h0,   64'h0, 1'b1, 64'h10, 1'b0); // ready low x3
      add(7'b0000000, 64'h0,   64'h0, 1'b1, 64'h10, 1'b0);
      add(7'b0000000, 64'h0,   64'h0, 1'b1, 64'h10, 1'b0);
      add(7'b1000000, 64'h0,   64'h0, 1'b1, 64'h10, 1'b0);
      add(7'b0110000, 64'h0,   64'h0, 1'b0, 64'h10, 1'b0); // instr + stall
      add(7'b0010000, 64'h0,   64'h0, 1'b0, 64'h10, 1'b0);
      add(7'b0010000, 64'h0,   64'h0, 1'b0, 64'h10, 1'b0);
      add(7'b0000000, 64'h0,   64'h0, 1'b0, 64'h10, 1'b0);
      add(7'b1000000, 64'h0,   64'h0, 1'b1, 64'h14, 1'b0);
      add(7'b0001001, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h14, 1'b0); // taken in WAIT
      add(7'b0000000, 64'h0,   64'h0, 1'b0, 64'hF8, 1'b1);
      add(7'b0100000, 64'h0,   64'h0, 1'b0, 64'hF8, 1'b0); // late instr dropped
      add(7'b1000000, 64'h0,   64'h0, 1'b1, 64'hF8, 1'b0);
      add(7'b0101100, 64'h200, 64'h8, 1'b0, 64'hF8, 1'b0); // not taken
      add(7'b1000000, 64'h0,   64'h0, 1'b1, 64'hFC, 1'b0);
      add(7'b0100000, 64'h0,   64'h0, 1'b0, 64'hFC, 1'b0);
      add(7'b0000000, 64'h0,   64'h0, 1'b1, 64'h100, 1'b0);

      do_reset();
      foreach (tv[i]) begin
         expect_o($sformatf("row%0d", i), tv[i].efv, tv[i].epc, tv[i].efl, 1'b0);
         drv(tv[i].in, tv[i].bpc, tv[i].bimm);
         tick();
      end

      // wrap: branch to -4, consume one instruction, PC wraps to 0
      expect_o("wrap0", 1'b1, 64'h100, 1'b0, 1'b0);
      drv(7'b0001001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF); tick();
      expect_o("wrap1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
      drv(7'b0000000, 64'h0, 64'h0); tick();
      expect_o("wrap2", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
      drv(7'b1000000, 64'h0, 64'h0); tick();
      expect_o("wrap3", 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
      drv(7'b0100000, 64'h0, 64'h0); tick();
      expect_o("wrap4", 1'b1, 64'h0, 1'b0, 1'b0);

      // misaligned target 0x102 + 4 = 0x106
      drv(7'b0001001, 64'h102, 64'h1); tick();
`ifdef PC_SEQ_ALIGN_TRAP_EN
      chk("mis1.Trap",  64'(Trap), 64'h1);
      chk("mis1.FetchValid", 64'(FetchValid), 64'h0);
      chk("mis1.Flush", 64'(Flush), 64'h1);
      drv(7'b0000000, 64'h0, 64'h0); tick();
      chk("mis2.Trap",  64'(Trap), 64'h1);
      chk("mis2.FetchValid", 64'(FetchValid), 64'h0);
      drv(7'b1101001, 64'h0, 64'h40); tick();
      chk("mis3.Trap",  64'(Trap), 64'h1);
      chk("mis3.FetchValid", 64'(FetchValid), 64'h0);
`else
      expect_o("mis1", 1'b0, 64'h104, 1'b1, 1'b0);
      drv(7'b0000000, 64'h0, 64'h0); tick();
      expect_o("mis2", 1'b1, 64'h104, 1'b0, 1'b0);
      tick();
      expect_o("mis3", 1'b1, 64'h104, 1'b0, 1'b0);
`endif

      // reset while a fetch is outstanding; its late response must be ignored
      do_reset();
      expect_o("mr0", 1'b0, 64'h0, 1'b0, 1'b0);
      drv(7'b1000000, 64'h0, 64'h0); tick();
      expect_o("mr1", 1'b1, 64'h0, 1'b0, 1'b0);
      tick();
      expect_o("mr2", 1'b0, 64'h0, 1'b0, 1'b0);
      drv(7'b0100000, 64'h0, 64'h0); tick();
      expect_o("mr3", 1'b1, 64'h4, 1'b0, 1'b0);
      drv(7'b1000000, 64'h0, 64'h0); tick();
      expect_o("mr4", 1'b0, 64'h4, 1'b0, 1'b0);
      drv(7'b0000000, 64'h0, 64'h0);
      #2 Reset = 1'b1;
      #1 expect_o("mr_async", 1'b0, 64'h0, 1'b0, 1'b0);
      @(posedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      expect_o("mr5", 1'b0, 64'h0, 1'b0, 1'b0);
      drv(7'b0100000, 64'h0, 64'h0); tick();
      expect_o("mr6", 1'b1, 64'h0, 1'b0, 1'b0);
      tick();
      expect_o("mr7", 1'b1, 64'h0, 1'b0, 1'b0);

      // randomized run against the reference model (aligned branch sources)
      do_reset();
      m_fv = 1'b0; m_fl = 1'b0; m_boot = 1'b1; m_drain = 1'b0; m_got = 1'b0;
      owed = 0; m_pc = 64'h0;
      for (int i = 0; i < 400; i++) begin
         expect_o($sformatf("rnd%0d", i), m_fv, m_pc, m_fl, 1'b0);
         FetchReady   = 1'($urandom_range(0, 1));
         InstrValid   = ($urandom_range(0, 2) != 0);
         Stall        = ($urandom_range(0, 3) == 0);
         BrValid      = ($urandom_range(0, 5) == 0);
         Branch       = 1'($urandom_range(0, 1));
         ALUZero      = 1'($urandom_range(0, 1));
         Uncondbranch = ($urandom_range(0, 2) == 0);
         BrPC         = {$urandom, $urandom} & ~64'h3;
         BrImm        = {32'h0, $urandom_range(0, 64)} - 64'd32;
         @(posedge CLK);
         model_step();
         @(negedge CLK);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter: RESET_PC, 64'h0, PC loaded on reset.
REQ-002 SHALL have parameter: PC_INCR, 4, sequential PC step in bytes.
REQ-003 SHALL use one clock and an asynchronous active-high reset: CLK in 1 rising-edge clock; Reset in 1 async active-high reset.
REQ-004 SHALL have port: FetchValid out 1, fetch request to instruction memory.
REQ-005 SHALL have port: FetchReady in 1, instruction memory accepts the request.
REQ-006 SHALL have port: FetchPC out 64, address of the request.
REQ-007 SHALL have port: InstrValid in 1, fetched instruction returned.
REQ-008 SHALL have port: Stall in 1, downstream cannot accept an instruction.
REQ-009 SHALL have port: BrValid in 1, branch resolved this cycle.
REQ-010 SHALL have port: BrPC in 64, PC of the resolved branch.
REQ-011 SHALL have port: BrImm in 64 signed, sign-extended word offset.
REQ-012 SHALL have ports: Branch, ALUZero, Uncondbranch in 1 each, branch condition inputs.
REQ-013 SHALL have port: Flush out 1, kill younger instructions.
REQ-014 SHALL have port: CurrentPC out 64, architectural PC register.
REQ-015 SHALL have port: Trap out 1, misaligned-target trap.

Function
REQ-016 SHALL implement states BOOT, FETCH, WAIT, HOLD, REDIRECT, TRAP.
REQ-017 SHALL leave BOOT for FETCH after exactly one cycle, with FetchValid=0 in BOOT.
REQ-018 SHALL in FETCH drive FetchValid=1 with FetchPC=CurrentPC.
REQ-019 SHALL hold FetchPC stable while FetchValid=1 and FetchReady=0.
REQ-020 SHALL move FETCH->WAIT on FetchValid&&FetchReady, setting an outstanding flag.
REQ-021 SHALL clear the outstanding flag on InstrValid.
REQ-022 SHALL on InstrValid&&!Stall in WAIT set CurrentPC<=CurrentPC+PC_INCR and go to FETCH.
REQ-023 SHALL on InstrValid&&Stall in WAIT go to HOLD, then on Stall=0 in HOLD increment PC and go to FETCH.
REQ-024 SHALL treat a branch as taken when BrValid && ((ALUZero&&Branch)||Uncondbranch), ignoring a not-taken BrValid.
REQ-025 SHALL on a taken branch in FETCH, WAIT or HOLD load CurrentPC<=BrPC+(BrImm<<<2) modulo 2^64, with priority over increment and Stall.
REQ-026 SHALL on a taken branch assert Flush=1 for exactly the next cycle and enter REDIRECT.
REQ-027 SHALL in REDIRECT drop any InstrValid for the outstanding fetch without a PC change, and go to FETCH once no fetch is outstanding.
REQ-028 SHALL ignore BrValid in BOOT, REDIRECT and TRAP.
REQ-029 SHALL wrap PC arithmetic: 64'hFFFF_FFFF_FFFF_FFFC+4 -> 0.
REQ-030 SHALL register all outputs except FetchPC, which equals CurrentPC.

Reset
REQ-031 SHALL on Reset asynchronously force state=BOOT, CurrentPC=RESET_PC, FetchValid=0, Flush=0, Trap=0, outstanding=0.
REQ-032 SHALL abandon any in-flight fetch on Reset mid-operation; a later InstrValid is ignored until FETCH is re-entered.

Configuration
REQ-033 SHALL use macro PC_SEQ_ALIGN_TRAP_EN: when defined, a taken target with bits[1:0]!=0 enters TRAP with Trap=1 and FetchValid=0 until Reset; when undefined, target bits[1:0] are forced to 0 and Trap is tied 0.

Structure
REQ-034 SHALL place the state enum typedef, PC width (64) and PC_INCR default in shared package pc_seq_pkg.
REQ-035 SHALL implement target computation and taken decode in combinational sub-module pc_target_calc.

Verification
REQ-036 SHALL cover reset release with RESET_PC=0: BOOT for 1 cycle, then FetchValid=1, FetchPC=0; with FetchReady and InstrValid each cycle, FetchPC sequence is 0,4,8.
REQ-037 SHALL cover backpressure: FetchReady=0 for 3 cycles -> FetchPC held at 0x10; Stall=1 two cycles after InstrValid -> PC stays 0x10 until Stall=0.
REQ-038 SHALL cover taken branch: BrPC=0x100, BrImm=-2, Uncondbranch=1 -> Flush high 1 cycle, next FetchPC=0xF8; late InstrValid dropped.
REQ-039 SHALL cover not-taken branch: BrValid=1, Branch=1, ALUZero=0 -> no Flush, PC increments normally.
REQ-040 SHALL cover wrap: PC=0xFFFF_FFFF_FFFF_FFFC, instruction accepted -> next FetchPC=0.
REQ-041 SHALL cover misalignment: BrPC=0x102, BrImm=1 taken -> Trap=1 and FetchValid=0 with macro; FetchPC=0x104 without.
